seq_detector_moore_param: RTL and testbench

Parametrised Moore-style serial pattern detector with a detection counter.
- Successor to the fixed-pattern Moore detector: runtime-programmable pattern and length, overlap/non-overlap mode, input qualifier, and a counter that saturates or wraps.
- Sits between a debounced serial input source (switch/PMOD) and LED/7-segment display logic on the Basys3 board.

---
 rtl/seq_detector_moore_param_pkg.sv | 25 ++
 rtl/seq_detector_moore_param_sat_counter.sv | 42 ++++
 rtl/seq_detector_moore_param.sv | 125 ++++++++++++
 tb/tb_seq_detector_moore_param.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_moore_param_pkg.sv
// Shared types and helpers for the parametrised Moore sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding and the pattern-length clamp helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,  // fewer than len bits collected since last restart
    ST_HUNT   = 2'd1,  // enough bits collected, last bit did not match
    ST_DETECT = 2'd2   // last accepted bit completed a match
  } state_e;

  // A zero length means "one bit"; anything past the history depth is
  // limited to the history depth.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) begin
      return 1;
    end
    if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_detector_moore_param_sat_counter.sv
// Detection counter that either saturates at all-ones or wraps to zero.
// Latency: count reflects inc/clr on the edge after they are sampled.
// Backpressure: none; inc is accepted every cycle, clr wins over inc.
// Ports: clk, rst (async active-high), inc, clr -> count.
module sat_counter #(
  parameter int COUNT_W  = 4,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if ((SATURATE != 0) && (count_q == '1)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_moore_param.sv
// Runtime-programmable serial pattern detector (Moore) with detection counter.
// Latency: detected/count update on the edge after the final matching bit.
// Backpressure: none; ain is qualified by ain_valid, idle cycles hold state.
// Ports: sys_clock, reset (async active-high), ain/ain_valid serial input,
//        cfg_load/cfg_pattern/cfg_len/cfg_overlap config, clear -> count, detected.
module seq_detector_moore_param
  import seq_det_pkg::*;
#(
  parameter int PATTERN_MAX = 8,
  parameter int COUNT_W     = 4,
  parameter int SATURATE    = 1,
  parameter int LEN_W       = $clog2(PATTERN_MAX + 1)
) (
  input  logic                   sys_clock,
  input  logic                   reset,
  input  logic                   ain,
  input  logic                   ain_valid,
  input  logic                   cfg_load,
  input  logic [PATTERN_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_overlap,
  input  logic                   clear,
  output logic [COUNT_W-1:0]     count,
  output logic                   detected
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PATTERN_MAX);

  state_e                 state_q, state_d;
  logic [PATTERN_MAX-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]       fill_q, fill_d;
  logic [PATTERN_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   ovl_q, ovl_d;
  logic                   detected_q, detected_d;

  logic [PATTERN_MAX-1:0] mask;
  logic [PATTERN_MAX-1:0] hist_sh;
  logic [LEN_W-1:0]       fill_inc;
  logic                   match;
  logic                   cnt_inc;

  // Low len bits set; len is already clamped to 1..PATTERN_MAX.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PATTERN_MAX; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign hist_sh  = {hist_q[PATTERN_MAX-2:0], ain};
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  // fill_inc saturates at PATTERN_MAX >= len, so it equals fill+1 whenever
  // that matters for the length check.
  assign match    = ((hist_sh & mask) == (pat_q & mask)) && (fill_inc >= len_q);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_inc = 1'b0;

    if (clear || cfg_load) begin
      // Both restart collection; any same-cycle ain bit is dropped.
      state_d = ST_FILL;
      hist_d  = '0;
      fill_d  = '0;
      if (cfg_load) begin
        pat_d = cfg_pattern;
        len_d = LEN_W'(clamp_len(int'(cfg_len), PATTERN_MAX));
        ovl_d = cfg_overlap;
      end
    end else if (ain_valid) begin
      hist_d = hist_sh;
      if (match) begin
        state_d = ST_DETECT;
        cnt_inc = 1'b1;
        // Non-overlap: forget collected bits so the next match needs len new ones.
        fill_d  = ovl_q ? fill_inc : '0;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc >= len_q) ? ST_HUNT : ST_FILL;
      end
    end

    detected_d = (state_d == ST_DETECT);
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      hist_q     <= '0;
      fill_q     <= '0;
      pat_q      <= '0;
      len_q      <= LEN_W'(1);
      ovl_q      <= 1'b1;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      detected_q <= detected_d;
    end
  end

  assign detected = detected_q;

  sat_counter #(
    .COUNT_W  (COUNT_W),
    .SATURATE (SATURATE)
  ) u_cnt (
    .clk   (sys_clock),
    .rst   (reset),
    .inc   (cnt_inc),
    .clr   (clear),
    .count (count)
  );

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Bench for seq_detector_moore_param: a saturating and a wrapping instance
// share all inputs; directed vectors with hand-computed expectations.
module tb_seq_detector_moore_param;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       ain, ain_valid, cfg_load, cfg_overlap, clear;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [3:0] count_s, count_w;
  logic       det_s, det_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clock = ~sys_clock;

  seq_detector_moore_param #(.PATTERN_MAX(8), .COUNT_W(4), .SATURATE(1)) dut (
    .sys_clock(sys_clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clear(clear), .count(count_s), .detected(det_s)
  );

  seq_detector_moore_param #(.PATTERN_MAX(8), .COUNT_W(4), .SATURATE(0)) dut_w (
    .sys_clock(sys_clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clear(clear), .count(count_w), .detected(det_w)
  );

  typedef struct packed {
    logic       a;
    logic       v;
    logic       ld;
    logic       cl;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       exp_det;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic e_det, input int e_cs, input int e_cw);
    chk({nm, " det"},   int'(det_s),   int'(e_det));
    chk({nm, " det_w"}, int'(det_w),   int'(e_det));
    chk({nm, " cnt_s"}, int'(count_s), e_cs);
    chk({nm, " cnt_w"}, int'(count_w), e_cw);
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the rising edge.
  task automatic step(input logic a, input logic v, input logic ld, input logic cl);
    ain = a; ain_valid = v; cfg_load = ld; clear = cl;
    @(posedge sys_clock);
    #1;
    ain = 1'b0; ain_valid = 1'b0; cfg_load = 1'b0; clear = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
  endtask

  task automatic add(input logic a, v, ld, cl, input logic [7:0] p,
                     input logic [3:0] l, input logic o, input logic ed, input logic [3:0] ec);
    vec_t t;
    t = '{a: a, v: v, ld: ld, cl: cl, pat: p, len: l, ovl: o, exp_det: ed, exp_cnt: ec};
    tbl.push_back(t);
  endtask

  initial begin
    logic [7:0] a5;
    reset = 1'b1;
    ain = 0; ain_valid = 0; cfg_load = 0; clear = 0;
    set_cfg(8'h00, 4'd0, 1'b0);

    // Overlap, pattern 1011 len 4: stream 1,0,1,1,0,1,1
    add(0,0,1,0, 8'h0B,4'd4,1, 0,4'd0);
    add(1,1,0,0, 8'h0B,4'd4,1, 0,4'd0);
    add(0,1,0,0, 8'h0B,4'd4,1, 0,4'd0);
    add(1,1,0,0, 8'h0B,4'd4,1, 0,4'd0);
    add(1,1,0,0, 8'h0B,4'd4,1, 1,4'd1);
    add(0,1,0,0, 8'h0B,4'd4,1, 0,4'd1);
    add(1,1,0,0, 8'h0B,4'd4,1, 0,4'd1);
    add(1,1,0,0, 8'h0B,4'd4,1, 1,4'd2);
    // Non-overlap; clear+load together zeroes count and latches config
    add(0,0,1,1, 8'h0B,4'd4,0, 0,4'd0);
    add(1,1,0,0, 8'h0B,4'd4,0, 0,4'd0);
    add(0,1,0,0, 8'h0B,4'd4,0, 0,4'd0);
    add(1,1,0,0, 8'h0B,4'd4,0, 0,4'd0);
    add(1,1,0,0, 8'h0B,4'd4,0, 1,4'd1);
    add(0,1,0,0, 8'h0B,4'd4,0, 0,4'd1);
    add(1,1,0,0, 8'h0B,4'd4,0, 0,4'd1);
    add(1,1,0,0, 8'h0B,4'd4,0, 0,4'd1);  // shares bits with the first match
    add(0,1,0,0, 8'h0B,4'd4,0, 0,4'd1);
    add(1,1,0,0, 8'h0B,4'd4,0, 0,4'd1);
    add(1,1,0,0, 8'h0B,4'd4,0, 1,4'd2);
    // len=0 acts as len=1, count kept across load
    add(0,0,1,0, 8'h01,4'd0,1, 0,4'd2);
    add(1,1,0,0, 8'h01,4'd0,1, 1,4'd3);
    add(0,1,0,0, 8'h01,4'd0,1, 0,4'd3);
    add(1,1,0,0, 8'h01,4'd0,1, 1,4'd4);
    add(1,1,0,0, 8'h01,4'd0,1, 1,4'd5);
    // len=12 clamps to 8; A5 only after all 8 bits
    add(0,0,1,0, 8'hA5,4'd12,1, 0,4'd5);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      add(a5[i],1,0,0, 8'hA5,4'd12,1, (i == 0), (i == 0) ? 4'd6 : 4'd5);
    end

    // Reset state while reset is held
    #2;
    chk_all("reset", 1'b0, 0, 0);
    #10;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      set_cfg(tbl[i].pat, tbl[i].len, tbl[i].ovl);
      step(tbl[i].a, tbl[i].v, tbl[i].ld, tbl[i].cl);
      chk_all($sformatf("vec%0d", i), tbl[i].exp_det, int'(tbl[i].exp_cnt), int'(tbl[i].exp_cnt));
    end

    // Saturate vs wrap: 20 consecutive 1s with len 1
    set_cfg(8'h01, 4'd1, 1'b1);
    step(0, 0, 1, 1);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 0, 0);
      chk_all($sformatf("sat%0d", i), 1'b1, (i > 15) ? 15 : i, i % 16);
    end

    // Qualifier gaps: pattern 111 len 3, valid every third cycle
    set_cfg(8'h07, 4'd3, 1'b1);
    step(0, 0, 1, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 0, 0);
      chk_all($sformatf("gap_v%0d", k), (k == 3), (k == 3) ? 1 : 0, (k == 3) ? 1 : 0);
      for (int j = 0; j < 2; j++) begin
        step(0, 0, 0, 0);
        chk_all($sformatf("gap_idle%0d_%0d", k, j), (k == 3), (k == 3) ? 1 : 0, (k == 3) ? 1 : 0);
      end
    end
    step(0, 1, 0, 0);
    chk_all("gap_drop", 1'b0, 1, 1);

    // Async reset mid-pattern; partial pattern must not be credited
    set_cfg(8'h0B, 4'd4, 1'b1);
    step(0, 0, 1, 1);
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk_all("pre_rst", 1'b1, 1, 1);
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 0, 0);
    #2 reset = 1'b0;
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk_all("post_rst", 1'b0, 0, 0);

    // Clear at count 3 keeps configuration, drops same-cycle bit
    set_cfg(8'h01, 4'd1, 1'b1);
    step(0, 0, 1, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk_all("pre_clr", 1'b1, 3, 3);
    set_cfg(8'h00, 4'd4, 1'b0);  // must be ignored without cfg_load
    step(1, 1, 0, 1);
    chk_all("clr", 1'b0, 0, 0);
    step(1, 1, 0, 0);
    chk_all("clr_cfg_kept", 1'b1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
